// File: rtl/sound_square_channel.sv
// Square-wave sound channel (CH1 with sweep, CH2 without): frame sequencer, length counter,
// volume envelope, optional frequency sweep and duty generator feeding a 4-bit amplitude.
module sound_square_channel #(
  parameter int CLK_HZ     = 33000000,
  parameter bit HAS_SWEEP  = 1'b1,
  parameter int PHASE_UNIT = 32
) (
  input  logic        I_CLK33MHZ,
  input  logic        I_RESET,
  input  logic [7:0]  I_NR0,
  input  logic [7:0]  I_NR1,
  input  logic [7:0]  I_NR2,
  input  logic [7:0]  I_NR3,
  input  logic [7:0]  I_NR4,
  input  logic        I_NR1_WR,
  input  logic        I_NR4_WR,
  output logic        O_ON,
  output logic [3:0]  O_SAMPLE,
  output logic [10:0] O_FREQ,
  output logic [3:0]  O_VOLUME
);

  localparam int FS_DIV = CLK_HZ / 512;
  localparam int FSW    = (FS_DIV > 1) ? $clog2(FS_DIV) : 1;
  localparam int PW     = $clog2(2048 * PHASE_UNIT + 1);
  localparam logic [FSW-1:0] FS_LAST = FSW'(FS_DIV - 1);

  function automatic logic [PW-1:0] phase_reload(input logic [10:0] f);
    return PW'((32'd2048 - 32'(f)) * 32'(PHASE_UNIT) - 32'd1);
  endfunction

  // Bit 11 of the result is the overflow flag; decrease can never underflow.
  function automatic logic [11:0] sweep_calc(input logic [10:0] sh, input logic dec,
                                             input logic [2:0] shift);
    logic [11:0] delta;
    delta = {1'b0, sh >> shift};
    return dec ? ({1'b0, sh} - delta) : ({1'b0, sh} + delta);
  endfunction

  logic [FSW-1:0] fs_cnt_q, fs_cnt_d;
  logic [2:0]     fs_step_q, fs_step_d;
  logic           on_q, on_d;
  logic [6:0]     len_q, len_d;
  logic [10:0]    freq_q, freq_d;
  logic [3:0]     vol_q, vol_d;
  logic [2:0]     env_tmr_q, env_tmr_d;
  logic [10:0]    shadow_q, shadow_d;
  logic [3:0]     sweep_tmr_q, sweep_tmr_d;
  logic           sweep_en_q, sweep_en_d;
  logic [PW-1:0]  phase_q, phase_d;
  logic [2:0]     duty_idx_q, duty_idx_d;
  logic [3:0]     sample_q, sample_d;

  logic        fs_tick, len_clk, sweep_clk, env_clk;
  logic        trigger, dac_on;
  logic [10:0] reg_freq;
  logic [2:0]  sweep_period, sweep_shift;
  logic        sweep_dec;
  logic [3:0]  sweep_reload;
  logic [11:0] sweep_new, sweep_next, trig_calc;
  logic [7:0]  duty_pat;
  logic        unused_bits;

  assign unused_bits = ^{I_NR0[7], I_NR4[5:3]};

  assign fs_tick   = (fs_cnt_q == FS_LAST);
  assign len_clk   = fs_tick & ~fs_step_q[0];
  assign sweep_clk = fs_tick & (fs_step_q[1:0] == 2'b10);
  assign env_clk   = fs_tick & (fs_step_q == 3'd7);

  assign trigger      = I_NR4_WR & I_NR4[7];
  assign dac_on       = (I_NR2[7:3] != 5'd0);
  assign reg_freq     = {I_NR4[2:0], I_NR3};
  assign sweep_period = I_NR0[6:4];
  assign sweep_dec    = I_NR0[3];
  assign sweep_shift  = I_NR0[2:0];
  assign sweep_reload = (sweep_period == 3'd0) ? 4'd8 : {1'b0, sweep_period};
  assign sweep_new    = sweep_calc(shadow_q, sweep_dec, sweep_shift);
  assign sweep_next   = sweep_calc(sweep_new[10:0], sweep_dec, sweep_shift);
  assign trig_calc    = sweep_calc(reg_freq, sweep_dec, sweep_shift);

  always_comb begin
    duty_pat = 8'b0111_1110;
    case (I_NR1[7:6])
      2'd0:    duty_pat = 8'b0000_0001;
      2'd1:    duty_pat = 8'b1000_0001;
      2'd2:    duty_pat = 8'b1000_0111;
      default: duty_pat = 8'b0111_1110;
    endcase
  end

  always_comb begin
    fs_cnt_d    = fs_tick ? '0 : fs_cnt_q + FSW'(1);
    fs_step_d   = fs_tick ? fs_step_q + 3'd1 : fs_step_q;
    on_d        = on_q;
    len_d       = len_q;
    freq_d      = freq_q;
    vol_d       = vol_q;
    env_tmr_d   = env_tmr_q;
    shadow_d    = shadow_q;
    sweep_tmr_d = sweep_tmr_q;
    sweep_en_d  = sweep_en_q;
    phase_d     = phase_q;
    duty_idx_d  = duty_idx_q;

    // Without an active sweep the output frequency simply mirrors the registers.
    if (!sweep_en_q) freq_d = reg_freq;

    if (on_q) begin
      if (phase_q == '0) begin
        phase_d    = phase_reload(freq_q);
        duty_idx_d = duty_idx_q + 3'd1;
      end else begin
        phase_d = phase_q - PW'(1);
      end
    end

    if (I_NR1_WR) begin
      len_d = 7'd64 - {1'b0, I_NR1[5:0]};
    end else if (len_clk && I_NR4[6] && len_q != 7'd0) begin
      len_d = len_q - 7'd1;
      if (len_q == 7'd1) on_d = 1'b0;
    end

    if (env_clk && I_NR2[2:0] != 3'd0) begin
      if (env_tmr_q <= 3'd1) begin
        env_tmr_d = I_NR2[2:0];
        if (I_NR2[3] && vol_q != 4'd15) vol_d = vol_q + 4'd1;
        else if (!I_NR2[3] && vol_q != 4'd0) vol_d = vol_q - 4'd1;
      end else begin
        env_tmr_d = env_tmr_q - 3'd1;
      end
    end

    if (HAS_SWEEP && sweep_clk) begin
      if (sweep_tmr_q <= 4'd1) begin
        sweep_tmr_d = sweep_reload;
        if (sweep_en_q && sweep_period != 3'd0) begin
          if (sweep_new[11]) begin
            on_d = 1'b0;
          end else if (sweep_shift != 3'd0) begin
            shadow_d = sweep_new[10:0];
            freq_d   = sweep_new[10:0];
            if (sweep_next[11]) on_d = 1'b0;
          end
        end
      end else begin
        sweep_tmr_d = sweep_tmr_q - 4'd1;
      end
    end

    // A trigger overrides whatever the frame-sequencer clocks did this cycle.
    if (trigger) begin
      on_d       = 1'b1;
      if (!I_NR1_WR) len_d = (len_q == 7'd0) ? 7'd64 : len_q;
      freq_d     = reg_freq;
      vol_d      = I_NR2[7:4];
      env_tmr_d  = I_NR2[2:0];
      phase_d    = phase_reload(reg_freq);
      duty_idx_d = duty_idx_q;
      if (HAS_SWEEP) begin
        shadow_d    = reg_freq;
        sweep_tmr_d = sweep_reload;
        sweep_en_d  = (sweep_period != 3'd0) || (sweep_shift != 3'd0);
        if (sweep_shift != 3'd0 && trig_calc[11]) on_d = 1'b0;
      end else begin
        sweep_en_d = 1'b0;
      end
    end

    if (!dac_on) on_d = 1'b0;

    sample_d = (on_q && duty_pat[duty_idx_q]) ? vol_q : 4'd0;
  end

  always_ff @(posedge I_CLK33MHZ) begin
    if (I_RESET) begin
      fs_cnt_q    <= '0;
      fs_step_q   <= '0;
      on_q        <= 1'b0;
      len_q       <= '0;
      freq_q      <= '0;
      vol_q       <= '0;
      env_tmr_q   <= '0;
      shadow_q    <= '0;
      sweep_tmr_q <= '0;
      sweep_en_q  <= 1'b0;
      phase_q     <= '0;
      duty_idx_q  <= '0;
      sample_q    <= '0;
    end else begin
      fs_cnt_q    <= fs_cnt_d;
      fs_step_q   <= fs_step_d;
      on_q        <= on_d;
      len_q       <= len_d;
      freq_q      <= freq_d;
      vol_q       <= vol_d;
      env_tmr_q   <= env_tmr_d;
      shadow_q    <= shadow_d;
      sweep_tmr_q <= sweep_tmr_d;
      sweep_en_q  <= sweep_en_d;
      phase_q     <= phase_d;
      duty_idx_q  <= duty_idx_d;
      sample_q    <= sample_d;
    end
  end

  assign O_ON     = on_q;
  assign O_SAMPLE = sample_q;
  assign O_FREQ   = freq_q;
  assign O_VOLUME = vol_q;

endmodule
